// File: rtl/scmp_bus_responder.sv
// SC/MP external-bus target responder: latches address/flags on ADS_n, then
// services one read or write strobe through a req/ack memory port.
module scmp_bus_responder #(
    parameter int AW          = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_ADS_n,
    input  logic          bus_RD_n,
    input  logic          bus_WR_n,
    input  logic [AW-1:0] bus_addr,
    input  logic          bus_F_R,
    input  logic          bus_F_I,
    input  logic          bus_F_D,
    input  logic          bus_F_H,
    input  logic [7:0]    bus_d_o,
    output logic [7:0]    bus_d_i,
    output logic          bus_hold,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic [3:0]    flags_o,
    output logic          fetch_o,
    output logic          halt_o,
    output logic          err_o
);

    typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, WR_WAIT, HOLD, S_END} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       accept;

    // ADS starts a new cycle anywhere except while a memory access is in flight.
    assign accept = !bus_ADS_n && (state != RD_WAIT) && (state != WR_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_d_i   <= '0;
            bus_hold  <= 1'b0;
            mem_addr  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            flags_o   <= '0;
            fetch_o   <= 1'b0;
            halt_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            fetch_o <= 1'b0;
            halt_o  <= 1'b0;
            err_o   <= 1'b0;
            if (accept) begin
                mem_addr <= bus_addr;
                flags_o  <= {bus_F_H, bus_F_D, bus_F_I, bus_F_R};
                fetch_o  <= bus_F_I;
                halt_o   <= bus_F_H;
                err_o    <= (state != IDLE);
                bus_hold <= 1'b1;
                cnt      <= '0;
                state    <= ADDR;
            end else begin
                case (state)
                    ADDR: begin
                        if (!bus_RD_n) begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            err_o   <= !bus_WR_n;
                            state   <= RD_WAIT;
                        end else if (!bus_WR_n) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= bus_d_o;
                            state     <= WR_WAIT;
                        end
                    end
                    RD_WAIT, WR_WAIT: begin
                        err_o <= !bus_ADS_n;
                        if (mem_ack) begin
                            if (state == RD_WAIT) bus_d_i <= mem_rdata;
                            mem_req <= 1'b0;
                            cnt     <= 4'(WAIT_STATES);
                            state   <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            bus_hold <= 1'b0;
                            state    <= S_END;
                        end
                    end
                    S_END: if (bus_RD_n && bus_WR_n) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scmp_bus_responder.sv
// Directed bench: two responders (WAIT_STATES 0 and 3) share one bus and memory stimulus.
module tb_scmp_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n, ads_n, rd_n, wr_n, f_r, f_i, f_d, f_h, ack;
    logic [15:0] addr;
    logic [7:0]  d_o, rdata;

    logic [7:0]  a_d_i, b_d_i, a_wdata, b_wdata;
    logic        a_hold, b_hold, a_req, b_req, a_we, b_we;
    logic        a_fetch, b_fetch, a_halt, b_halt, a_err, b_err;
    logic [15:0] a_maddr, b_maddr;
    logic [3:0]  a_flags, b_flags;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    scmp_bus_responder #(.AW(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus_ADS_n(ads_n), .bus_RD_n(rd_n), .bus_WR_n(wr_n),
        .bus_addr(addr), .bus_F_R(f_r), .bus_F_I(f_i), .bus_F_D(f_d), .bus_F_H(f_h),
        .bus_d_o(d_o), .bus_d_i(a_d_i), .bus_hold(a_hold), .mem_addr(a_maddr),
        .mem_req(a_req), .mem_we(a_we), .mem_wdata(a_wdata), .mem_rdata(rdata),
        .mem_ack(ack), .flags_o(a_flags), .fetch_o(a_fetch), .halt_o(a_halt), .err_o(a_err));

    scmp_bus_responder #(.AW(16), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus_ADS_n(ads_n), .bus_RD_n(rd_n), .bus_WR_n(wr_n),
        .bus_addr(addr), .bus_F_R(f_r), .bus_F_I(f_i), .bus_F_D(f_d), .bus_F_H(f_h),
        .bus_d_o(d_o), .bus_d_i(b_d_i), .bus_hold(b_hold), .mem_addr(b_maddr),
        .mem_req(b_req), .mem_we(b_we), .mem_wdata(b_wdata), .mem_rdata(rdata),
        .mem_ack(ack), .flags_o(b_flags), .fetch_o(b_fetch), .halt_o(b_halt), .err_o(b_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked at the same point.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ads(input logic [15:0] a, input logic fi, input logic fh);
        ads_n = 1'b0; addr = a; f_i = fi; f_h = fh; f_r = 1'b0; f_d = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ads_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = '0;
        f_r = 1'b0; f_i = 1'b0; f_d = 1'b0; f_h = 1'b0; d_o = '0; rdata = '0; ack = 1'b0;
        tick(3);
        chk("rst_hold", a_hold, 0);
        chk("rst_req", a_req, 0);
        chk("rst_outs", {a_d_i, a_maddr, a_wdata, a_flags, a_fetch, a_halt, a_err}, 0);
        rst_n = 1'b1;
        tick(2);

        // Read, WAIT_STATES=0, immediate ack
        ads(16'h0123, 1'b1, 1'b0);
        tick();
        chk("rd_fetch", a_fetch, 1);
        chk("rd_hold_e0", a_hold, 1);
        chk("rd_addr", a_maddr, 16'h0123);
        ads_n = 1'b1; rd_n = 1'b0; ack = 1'b1; rdata = 8'hA5;
        tick();
        chk("rd_req_e1", {a_req, a_we}, 2'b10);
        chk("rd_fetch_once", a_fetch, 0);
        chk("rd_hold_e1", a_hold, 1);
        tick();
        chk("rd_data", a_d_i, 8'hA5);
        chk("rd_req_e2", a_req, 0);
        chk("rd_hold_e2", a_hold, 1);
        tick();
        chk("rd_hold_e3", a_hold, 0);
        rd_n = 1'b1; ack = 1'b0;
        tick(8);

        // Write, WAIT_STATES=3, ack two cycles late
        ads(16'h0F00, 1'b0, 1'b0);
        tick();
        ads_n = 1'b1; wr_n = 1'b0; d_o = 8'h3C;
        tick();
        chk("wr_req_e1", {b_req, b_we, b_wdata}, {2'b11, 8'h3C});
        chk("wr_addr", b_maddr, 16'h0F00);
        d_o = 8'hFF;
        tick();
        chk("wr_req_e2", {b_req, b_wdata}, {1'b1, 8'h3C});
        tick();
        chk("wr_req_e3", {b_req, b_we, b_wdata, b_maddr}, {2'b11, 8'h3C, 16'h0F00});
        ack = 1'b1;
        tick();
        chk("wr_req_drop", b_req, 0);
        ack = 1'b0;
        tick(3);
        chk("wr_hold_ack3", b_hold, 1);
        tick();
        chk("wr_hold_ack4", b_hold, 0);
        wr_n = 1'b1;
        tick(8);

        // Halt + fetch flags, then RD and WR together
        ads(16'h0042, 1'b1, 1'b1);
        tick();
        chk("halt_pulse", {a_halt, a_fetch}, 2'b11);
        chk("halt_flags", a_flags, 4'b1010);
        ads_n = 1'b1;
        tick();
        chk("halt_once", {a_halt, a_fetch}, 2'b00);
        rd_n = 1'b0; wr_n = 1'b0; d_o = 8'h77;
        tick();
        chk("both_err", a_err, 1);
        chk("both_rd_wins", {a_req, a_we}, 2'b10);
        ack = 1'b1; rdata = 8'h5A;
        tick();
        chk("both_err_clr", a_err, 0);
        chk("both_data", a_d_i, 8'h5A);
        rd_n = 1'b1; wr_n = 1'b1; ack = 1'b0;
        tick();
        chk("both_hold", a_hold, 0);
        tick(8);

        // ADS during RD_WAIT, then early strobe release
        ads(16'h1111, 1'b0, 1'b0);
        tick();
        ads_n = 1'b1; rd_n = 1'b0;
        tick();
        chk("rw_req", a_req, 1);
        ads(16'h2222, 1'b0, 1'b0);
        tick();
        chk("rw_err", a_err, 1);
        chk("rw_addr_kept", {a_req, a_maddr}, {1'b1, 16'h1111});
        ads_n = 1'b1;
        tick();
        chk("rw_err_clr", a_err, 0);
        chk("rw_addr_kept2", a_maddr, 16'h1111);
        rd_n = 1'b1; ack = 1'b1; rdata = 8'hC3;
        tick();
        chk("er_done", {a_req, a_hold, a_d_i}, {2'b01, 8'hC3});
        ack = 1'b0;
        tick();
        chk("er_hold", a_hold, 0);
        tick();
        ads(16'h0456, 1'b1, 1'b0);
        tick();
        chk("er_idle_ads", {a_err, a_fetch, a_hold}, 3'b011);
        ads_n = 1'b1;

        // Reset during WR_WAIT
        wr_n = 1'b0; d_o = 8'h99;
        tick();
        chk("rs_req_pre", {a_req, a_we}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async", {a_req, a_hold, a_err}, 3'b000);
        chk("rs_addr", a_maddr, 16'h0);
        ack = 1'b1;
        tick();
        rst_n = 1'b1; wr_n = 1'b1;
        tick();
        chk("rs_ack_ignored", {a_req, a_d_i}, 9'h0);
        ack = 1'b0;
        ads(16'h0456, 1'b0, 1'b0);
        tick();
        chk("rs_ads", {a_fetch, a_hold, a_maddr}, {2'b01, 16'h0456});
        ads_n = 1'b1; rd_n = 1'b0; ack = 1'b1; rdata = 8'h3C;
        tick();
        chk("rs_req", a_req, 1);
        tick();
        chk("rs_data", a_d_i, 8'h3C);
        tick();
        chk("rs_hold", a_hold, 0);
        rd_n = 1'b1; ack = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/scmp_bus_responder.md
Name: scmp_bus_responder

Overview:
- Target-side responder for the SC/MP external bus driven by the CPU microcode sequencer.
- Latches the address and status flags (F_R/F_I/F_D/F_H) on the ADS_n strobe, then services the RD_n or WR_n strobe against a synchronous req/ack memory port.
- Holds the CPU with bus_hold until data is valid or written, plus WAIT_STATES extra cycles.
- Sits between the CPU core bus pins and the RAM/ROM/peripheral fabric.

Parameters:
AW, 16, address width on bus and memory side
WAIT_STATES, 0, extra hold cycles after mem_ack (0..15)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
bus_ADS_n  in  1  address strobe, active low, one cycle
bus_RD_n  in  1  read strobe, active low, level
bus_WR_n  in  1  write strobe, active low, level
bus_addr  in  AW  address, valid while ADS_n low
bus_F_R  in  1  read-cycle flag, valid with ADS_n
bus_F_I  in  1  instruction-fetch flag, valid with ADS_n
bus_F_D  in  1  delay-cycle flag, valid with ADS_n
bus_F_H  in  1  halt flag, valid with ADS_n
bus_d_o  in  8  CPU write data, valid while WR_n low
bus_d_i  out  8  read data returned to CPU
bus_hold  out  1  1 = CPU must extend the strobe
mem_addr  out  AW  latched address
mem_req  out  1  access request, held until accepted
mem_we  out  1  1 = write, 0 = read, valid with mem_req
mem_wdata  out  8  write data, valid with mem_req
mem_rdata  in  8  read data, valid with mem_ack on a read
mem_ack  in  1  transfer completes at an edge with mem_req & mem_ack
flags_o  out  4  latched {F_H,F_D,F_I,F_R}
fetch_o  out  1  one-cycle pulse: ADS accepted with F_I=1
halt_o  out  1  one-cycle pulse: ADS accepted with F_H=1
err_o  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset: state IDLE. All outputs 0, including bus_d_i, mem_addr, mem_wdata, flags_o and the counter. Reset mid-access drops mem_req immediately and a pending ack is ignored.
- All outputs are registered. Strobes are sampled at posedge.
- IDLE: ADS_n=0 -> latch bus_addr into mem_addr and flags into flags_o; bus_hold<=1; pulse fetch_o/halt_o per flags; go ADDR.
- ADDR, RD_n=0 -> mem_req<=1, mem_we<=0; go RD_WAIT.
- ADDR, WR_n=0 -> mem_req<=1, mem_we<=1, mem_wdata<=bus_d_o; go WR_WAIT.
- ADDR, RD_n=0 and WR_n=0 together -> err_o pulse; read wins.
- ADDR, neither strobe -> stay in ADDR.
- RD_WAIT: at an edge with mem_ack -> bus_d_i<=mem_rdata, mem_req<=0, cnt<=WAIT_STATES, go HOLD.
- WR_WAIT: at an edge with mem_ack -> mem_req<=0, cnt<=WAIT_STATES, go HOLD.
- HOLD: cnt!=0 -> cnt--. cnt==0 -> bus_hold<=0, go END. With WAIT_STATES=0, HOLD lasts exactly one cycle.
- END: stay until both RD_n and WR_n are high, then go IDLE.
- bus_d_i keeps its last read value until the next read completes.
- Minimum read latency with WAIT_STATES=0 and an immediate ack:
  - edge0: ADS sampled
  - edge1: RD_n sampled
  - edge2: ack, data loaded
  - edge3: bus_hold falls
  - In general, bus_hold falls 3+WAIT_STATES edges after the ADS edge.
- ADS_n=0 in ADDR, HOLD or END: err_o pulse, then treat as a new cycle. This re-latches address and flags, keeps bus_hold=1 and goes to ADDR. The current HOLD count is discarded.
- ADS_n=0 in RD_WAIT or WR_WAIT: err_o pulse, strobe ignored. The outstanding access completes normally.
- Strobe released before completion (RD_n/WR_n high in RD_WAIT/WR_WAIT/HOLD): the memory access still completes and the FSM proceeds. END exits immediately.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req=1.
- bus_F_R is latched and reported only. Direction is taken from the strobes.

Test Plan:
- Read, WAIT_STATES=0: ADS with addr=0x0123, F_I=1; RD_n low next cycle; ack in the first req cycle with rdata=0xA5 -> fetch_o pulse at edge0+1; mem_addr=0x0123, mem_we=0; bus_d_i=0xA5; bus_hold high edges 1..3, low after edge3.
- Write, WAIT_STATES=3: ADS addr=0x0F00; WR_n low with bus_d_o=0x3C; ack delayed 2 cycles -> mem_req held 3 cycles with mem_wdata=0x3C stable; bus_hold drops 4 cycles after ack.
- Halt flag: ADS with F_H=1, F_I=1 -> halt_o and fetch_o each pulse exactly once; flags_o=4'b1010.
- Protocol errors: RD_n and WR_n low together in ADDR -> err_o pulse, mem_we=0. ADS during RD_WAIT -> err_o pulse; mem_addr unchanged until ack.
- Early release: RD_n rises while in RD_WAIT -> access completes on ack; END exits to IDLE next edge; bus_hold returns to 0.
- Reset mid-write: rst_n low during WR_WAIT with mem_req=1 -> mem_req, bus_hold and err_o are 0 asynchronously; after release, a fresh ADS read works.
